// File: rtl/mux_ctrl_pkg.sv
// Shared types and helpers for the 4-source round-robin mux arbiter.
package mux_ctrl_pkg;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {IDLE, GRANT} state_e;

  // First set request scanning ptr, ptr+1, ... mod NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data/handshake bundle between the sources, the arbiter and the sink.
interface mux_rr_arbiter_if #(parameter int DW = 8);
  logic [mux_ctrl_pkg::NUM_REQ-1:0] req;
  logic [DW-1:0]                    i0, i1, i2, i3;
  logic [DW-1:0]                    y;
  logic                             y_valid;
  logic                             y_ready;
  logic [mux_ctrl_pkg::NUM_REQ-1:0] gnt;
  logic                             s1, s0;
  logic                             busy;

  modport master (input req, i0, i1, i2, i3, y_ready,
                  output y, y_valid, gnt, s1, s0, busy);
  modport slave  (output req, i0, i1, i2, i3, y_ready,
                  input y, y_valid, gnt, s1, s0, busy);
endinterface

// File: rtl/mux4_bus.sv
// DW-wide 4:1 mux built from per-bit behavioural 4:1 muxes; index = {s1,s0}.
module mux4_bit (
  input  logic s1,
  input  logic s0,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  output logic y
);
  always_comb begin
    case ({s1, s0})
      2'b00:   y = i0;
      2'b01:   y = i1;
      2'b10:   y = i2;
      default: y = i3;
    endcase
  end
endmodule

module mux4_bus #(parameter int DW = 8) (
  input  logic          s1,
  input  logic          s0,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  input  logic [DW-1:0] i2,
  input  logic [DW-1:0] i3,
  output logic [DW-1:0] y
);
  for (genvar b = 0; b < DW; b++) begin : g_bit
    mux4_bit u_bit (
      .s1(s1), .s0(s0),
      .i0(i0[b]), .i1(i1[b]), .i2(i2[b]), .i3(i3[b]),
      .y(y[b])
    );
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one DW-bit valid/ready channel among four sources,
// each grant bounded to HOLD_MAX transferred beats.
module mux_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int DW       = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.master  bus
);
  localparam logic [3:0] LAST = 4'(HOLD_MAX - 1);
  localparam logic [3:0] SAT  = 4'(HOLD_MAX);

  state_e             state, state_nxt;
  logic [IDX_W-1:0]   sel, ptr, pick;
  logic [3:0]         beat_cnt;
  logic [NUM_REQ-1:0] gnt;
  logic               xfer, rel;

  assign pick = rr_pick(bus.req, ptr);
  assign xfer = bus.y_valid && bus.y_ready;
  // A dropped request releases immediately; otherwise the HOLD_MAX-th beat does.
  assign rel  = (state == GRANT) && (!bus.req[sel] || (xfer && beat_cnt == LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.req) state_nxt = GRANT;
      GRANT:   if (rel)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state == GRANT);
    bus.y_valid = (state == GRANT) && bus.req[sel];
  end

  // Grant, select, pointer and beat counter; sel holds through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (|bus.req) begin
        gnt      <= NUM_REQ'(1) << pick;
        sel      <= pick;
        beat_cnt <= '0;
      end
    end else if (rel) begin
      gnt <= '0;
      ptr <= sel + 1'b1;
    end else if (xfer && beat_cnt != SAT) begin
      beat_cnt <= beat_cnt + 4'd1;
    end
  end

  assign bus.gnt = gnt;
  assign bus.s1  = sel[1];
  assign bus.s0  = sel[0];

  mux4_bus #(.DW(DW)) u_mux (
    .s1(sel[1]), .s0(sel[0]),
    .i0(bus.i0), .i1(bus.i1), .i2(bus.i2), .i3(bus.i3),
    .y(bus.y)
  );
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboarded bench for mux_rr_arbiter: expected beats queued at stimulus, popped per transfer.
module tb_mux_rr_arbiter;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.DW(DW)) bus ();
  mux_rr_arbiter_if #(.DW(DW)) bus1 ();

  mux_rr_arbiter #(.DW(DW), .HOLD_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  mux_rr_arbiter #(.DW(DW), .HOLD_MAX(1)) dut_h1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_chk = 0;
  int n_pass = 0;
  int exp_q[$];

  function automatic logic [DW-1:0] dat(input int idx);
    case (idx)
      0:       return 8'h11;
      1:       return 8'h22;
      2:       return 8'hA5;
      default: return 8'h44;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_yv"}, 32'(bus.y_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_gnt(input string tag, input int idx);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(1) << idx);
    chk({tag, "_sel"}, 32'({bus.s1, bus.s0}), 32'(idx));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic push(input int idx, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(idx);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus1.req = '0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Each transfer (valid & ready, sampled mid-cycle) consumes one expected beat.
  always @(negedge clk) begin : mon
    int e;
    if (rst_n && bus.y_valid && bus.y_ready) begin
      chk("beat_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("beat_y", 32'(bus.y), 32'(dat(e)));
        chk("beat_sel", 32'({bus.s1, bus.s0}), 32'(e));
        chk("beat_gnt", 32'(bus.gnt), 32'(1) << e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.req = '0;  bus.y_ready = 1'b1;
    bus.i0 = dat(0); bus.i1 = dat(1); bus.i2 = dat(2); bus.i3 = dat(3);
    bus1.req = '0; bus1.y_ready = 1'b1;
    bus1.i0 = dat(0); bus1.i1 = dat(1); bus1.i2 = dat(2); bus1.i3 = dat(3);

    // Reset release with no requests
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      look();
      chk_idle("rst");
      chk("rst_sel", 32'({bus.s1, bus.s0}), 32'd0);
      tick();
    end

    // Single source: 4 beats, one bubble, re-grant
    do_reset();
    push(2, 5);
    bus.req = 4'b0100;
    tick(); look();
    chk_gnt("t2_g1", 2);
    chk("t2_yv", 32'(bus.y_valid), 32'd1);
    tick(); tick(); tick(); tick(); look();
    chk_idle("t2_bubble");
    tick(); look();
    chk_gnt("t2_g2", 2);
    tick(); bus.req = '0;
    tick(); look();
    chk_idle("t2_end");
    chk("t2_q", 32'(exp_q.size()), 32'd0);

    // All requesting: order 0,1,2,3,0
    do_reset();
    for (int g = 0; g < 5; g++) push(g % 4, 4);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick(); look();
      chk_gnt("t3_g", g % 4);
      tick(); tick(); tick(); tick(); look();
      chk_idle("t3_bubble");
    end
    #1 bus.req = '0;
    tick(); look();
    chk_idle("t3_end");
    chk("t3_q", 32'(exp_q.size()), 32'd0);

    // Stall mid-grant: grant and count hold, 4 beats total
    do_reset();
    push(1, 4);
    bus.req = 4'b0010;
    tick(); look();
    chk_gnt("t4_g", 1);
    tick(); bus.y_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      look();
      chk_gnt("t4_stall", 1);
      chk("t4_stall_yv", 32'(bus.y_valid), 32'd1);
      tick();
    end
    bus.y_ready = 1'b1;
    tick(); tick();
    look();
    chk_gnt("t4_last", 1);
    tick(); bus.req = '0;
    look();
    chk_idle("t4_end");
    chk("t4_q", 32'(exp_q.size()), 32'd0);

    // Pointer wrap 3 -> 0
    do_reset();
    push(3, 4); push(0, 1);
    bus.req = 4'b1000;
    tick(); look();
    chk_gnt("t5_g3", 3);
    tick(); bus.req = 4'b1001;
    tick(); tick(); tick(); look();
    chk_idle("t5_bubble");
    tick(); look();
    chk_gnt("t5_g0", 0);
    tick(); bus.req = '0;
    tick(); look();
    chk_idle("t5_end");
    chk("t5_q", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset during beat 2, then ptr=0 order
    do_reset();
    push(2, 1);
    bus.req = 4'b0100;
    tick(); look();
    chk_gnt("t6_g", 2);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_idle("t6_async");
    chk("t6_sel", 32'({bus.s1, bus.s0}), 32'd0);
    chk("t6_q", 32'(exp_q.size()), 32'd0);
    bus.req = 4'b1111;
    tick(); tick();
    rst_n = 1'b1;
    push(0, 1);
    tick(); look();
    chk_gnt("t6_first", 0);
    tick(); bus.req = '0;
    tick(); look();
    chk_idle("t6_end");
    chk("t6_q2", 32'(exp_q.size()), 32'd0);

    // HOLD_MAX=1: one beat per grant, bubble between
    do_reset();
    bus1.req = 4'b0001;
    tick(); look();
    chk("h1_gnt_a", 32'(bus1.gnt), 32'd1);
    chk("h1_yv_a", 32'(bus1.y_valid), 32'd1);
    chk("h1_y", 32'(bus1.y), 32'(dat(0)));
    tick(); look();
    chk("h1_gnt_b", 32'(bus1.gnt), 32'd0);
    chk("h1_yv_b", 32'(bus1.y_valid), 32'd0);
    tick(); look();
    chk("h1_gnt_c", 32'(bus1.gnt), 32'd1);
    #1 bus1.req = '0;
    tick(); look();
    chk("h1_gnt_d", 32'(bus1.gnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
